// File: rtl/pipe_stage_reg.sv
// ----------------------------------------------------------------------------
// pipe_stage_reg
//   Parametrised inter-stage pipeline register with a valid/ready handshake on
//   both sides, a synchronous flush, and an optional skid entry. With the skid
//   entry enabled, ready_o comes straight from a flop. This breaks the
//   combinational ready path from downstream to upstream.
//
// Parameters
//   DATA_W     payload width in bits (>= 1)
//   RESET_VAL  payload value of both entries after reset
//   FLUSH_VAL  payload value loaded into both entries on flush
//   SKID       1: main + skid entry, registered ready_o
//              0: single entry, combinational ready_o
//
// Ports
//   clk_i    in   1       clock, rising edge
//   rst_i    in   1       asynchronous active-low reset
//   valid_i  in   1       upstream payload valid
//   data_i   in   DATA_W  upstream payload
//   ready_o  out  1       stage accepts a payload this cycle
//   valid_o  out  1       main entry holds a valid payload
//   data_o   out  DATA_W  main entry payload
//   ready_i  in   1       downstream accepts the payload this cycle
//   flush_i  in   1       synchronous squash of held and incoming payloads
//   count_o  out  2       occupancy (main + skid), 0..2
// ----------------------------------------------------------------------------
module pipe_stage_reg #(
   parameter int                 DATA_W    = 32,
   parameter logic [DATA_W-1:0]  RESET_VAL = '0,
   parameter logic [DATA_W-1:0]  FLUSH_VAL = '0,
   parameter bit                 SKID      = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              valid_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              ready_o,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   input  logic              ready_i,
   input  logic              flush_i,
   output logic [1:0]        count_o
);

   logic              main_vld_p0;
   logic [DATA_W-1:0] main_dat_p0;
   logic              skid_vld_p0;
   logic              main_free;

   // The main entry is free next cycle when it is empty or is drained now.
   assign main_free = ~main_vld_p0 | ready_i;

   generate
      if (SKID) begin : g_skid
         logic              in_xfer;
         logic [DATA_W-1:0] skid_dat_p0;

         assign in_xfer = valid_i & ready_o;
         // Registered ready: the skid slot absorbs the one payload that can
         // arrive in the cycle the downstream stage first stalls.
         assign ready_o = ~skid_vld_p0;

         // ---- stage boundary: upstream -> main/skid entries ----
         always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
               main_vld_p0 <= 1'b0;
               skid_vld_p0 <= 1'b0;
               main_dat_p0 <= RESET_VAL;
               skid_dat_p0 <= RESET_VAL;
            end else if (flush_i) begin
               main_vld_p0 <= 1'b0;
               skid_vld_p0 <= 1'b0;
               main_dat_p0 <= FLUSH_VAL;
               skid_dat_p0 <= FLUSH_VAL;
            end else if (main_free) begin
               if (skid_vld_p0) begin
                  // Older skid payload goes first. ready_o is low, so no
                  // new payload can arrive in this cycle.
                  main_vld_p0 <= 1'b1;
                  main_dat_p0 <= skid_dat_p0;
                  skid_vld_p0 <= 1'b0;
               end else if (valid_i) begin
                  main_vld_p0 <= 1'b1;
                  main_dat_p0 <= data_i;
               end else begin
                  main_vld_p0 <= 1'b0;
               end
            end else if (in_xfer) begin
               skid_vld_p0 <= 1'b1;
               skid_dat_p0 <= data_i;
            end
         end
      end else begin : g_noskid
         assign skid_vld_p0 = 1'b0;
         assign ready_o     = main_free;

         // ---- stage boundary: upstream -> main entry ----
         always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
               main_vld_p0 <= 1'b0;
               main_dat_p0 <= RESET_VAL;
            end else if (flush_i) begin
               main_vld_p0 <= 1'b0;
               main_dat_p0 <= FLUSH_VAL;
            end else if (main_free) begin
               main_vld_p0 <= valid_i;
               if (valid_i) begin
                  main_dat_p0 <= data_i;
               end
            end
         end
      end
   endgenerate

   assign valid_o = main_vld_p0;
   assign data_o  = main_dat_p0;
   assign count_o = {1'b0, main_vld_p0} + {1'b0, skid_vld_p0};

endmodule
